// File: rtl/cpm_topk_serializer_if.sv
// Handshake and payload bundle between the top-K sorter, the serializer and
// the downstream writeback stage. master = environment, slave = serializer.
interface cpm_topk_serializer_if #(
  parameter int unsigned DATA_DW = 8,
  parameter int unsigned INFO_DW = 8,
  parameter int unsigned SORT_DW = 32,
  parameter int unsigned SORT_AW = $clog2(SORT_DW)
);

  logic                              clear;
  logic [SORT_AW:0]                  CFG_NUM;
  logic                              TOPK_DAT_VLD;
  logic [SORT_DW-1:0][DATA_DW-1:0]   TOPK_DAT_DAT;
  logic [SORT_DW-1:0][INFO_DW-1:0]   TOPK_DAT_INF;
  logic                              TOPK_DAT_RDY;
  logic                              OUT_DAT_VLD;
  logic                              OUT_DAT_RDY;
  logic                              OUT_DAT_LST;
  logic [DATA_DW-1:0]                OUT_DAT_DAT;
  logic [INFO_DW-1:0]                OUT_DAT_INF;
  logic [SORT_AW-1:0]                OUT_DAT_IDX;
  logic                              BUSY;

  modport master (
    output clear, CFG_NUM, TOPK_DAT_VLD, TOPK_DAT_DAT, TOPK_DAT_INF, OUT_DAT_RDY,
    input  TOPK_DAT_RDY, OUT_DAT_VLD, OUT_DAT_LST, OUT_DAT_DAT, OUT_DAT_INF,
           OUT_DAT_IDX, BUSY
  );

  modport slave (
    input  clear, CFG_NUM, TOPK_DAT_VLD, TOPK_DAT_DAT, TOPK_DAT_INF, OUT_DAT_RDY,
    output TOPK_DAT_RDY, OUT_DAT_VLD, OUT_DAT_LST, OUT_DAT_DAT, OUT_DAT_INF,
           OUT_DAT_IDX, BUSY
  );

endinterface

// File: rtl/cpm_topk_serializer.sv
// Snapshots the sorter's top-K arrays and replays them as a ranked serial
// stream (rank 0 = largest) with valid/ready/last handshake.
module cpm_topk_serializer #(
  parameter int unsigned DATA_DW = 8,
  parameter int unsigned INFO_DW = 8,
  parameter int unsigned SORT_DW = 32,
  parameter int unsigned SORT_AW = $clog2(SORT_DW)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  cpm_topk_serializer_if.slave     bus
);

  localparam int unsigned CNT_W = SORT_AW + 1;
  localparam logic [CNT_W-1:0] MAX_N = CNT_W'(SORT_DW);
  localparam logic [CNT_W-1:0] ONE_N = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e                          state_q, state_d;
  logic [SORT_AW-1:0]              idx_q, idx_d;
  logic [SORT_AW-1:0]              last_q, last_d;
  logic [SORT_DW-1:0][DATA_DW-1:0] buf_dat_q, buf_dat_d;
  logic [SORT_DW-1:0][INFO_DW-1:0] buf_inf_q, buf_inf_d;
  logic                            vld_q, vld_d;
  logic                            lst_q, lst_d;
  logic [DATA_DW-1:0]              dat_q, dat_d;
  logic [INFO_DW-1:0]              inf_q, inf_d;
  logic                            busy_q, busy_d;
  logic [CNT_W-1:0]                n_eff;
  logic [SORT_AW-1:0]              idx_inc;

  // State, snapshot buffers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      last_q    <= '0;
      buf_dat_q <= '0;
      buf_inf_q <= '0;
      vld_q     <= 1'b0;
      lst_q     <= 1'b0;
      dat_q     <= '0;
      inf_q     <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      buf_dat_q <= buf_dat_d;
      buf_inf_q <= buf_inf_d;
      vld_q     <= vld_d;
      lst_q     <= lst_d;
      dat_q     <= dat_d;
      inf_q     <= inf_d;
      busy_q    <= busy_d;
    end
  end

  // Next-state and next-output logic; clear overrides every state.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    last_d    = last_q;
    buf_dat_d = buf_dat_q;
    buf_inf_d = buf_inf_q;
    vld_d     = vld_q;
    lst_d     = lst_q;
    dat_d     = dat_q;
    inf_d     = inf_q;
    busy_d    = busy_q;
    idx_inc   = idx_q + SORT_AW'(1);
    // 0 or anything beyond the array size means "emit the whole array".
    n_eff     = ((bus.CFG_NUM == '0) || (bus.CFG_NUM > MAX_N)) ? MAX_N : bus.CFG_NUM;

    if (bus.clear) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      vld_d   = 1'b0;
      lst_d   = 1'b0;
      dat_d   = '0;
      inf_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.TOPK_DAT_VLD) begin
            state_d   = ST_SEND;
            buf_dat_d = bus.TOPK_DAT_DAT;
            buf_inf_d = bus.TOPK_DAT_INF;
            last_d    = SORT_AW'(n_eff - ONE_N);
            idx_d     = '0;
            vld_d     = 1'b1;
            lst_d     = (n_eff == ONE_N);
            // Buffer is not loaded yet on this edge, so entry 0 comes straight from the input.
            dat_d     = bus.TOPK_DAT_DAT[0];
            inf_d     = bus.TOPK_DAT_INF[0];
          end
        end
        ST_SEND: begin
          if (vld_q && bus.OUT_DAT_RDY) begin
            if (lst_q) begin
              state_d = ST_DONE;
              vld_d   = 1'b0;
              lst_d   = 1'b0;
            end else begin
              idx_d = idx_inc;
              dat_d = buf_dat_q[idx_inc];
              inf_d = buf_inf_q[idx_inc];
              lst_d = (idx_inc == last_q);
            end
          end
        end
        ST_DONE: begin
          // Hold off until the sorter drops its level-held valid.
          if (!bus.TOPK_DAT_VLD) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  // Upstream ready is a direct decode of the IDLE state.
  assign bus.TOPK_DAT_RDY = (state_q == ST_IDLE);
  assign bus.OUT_DAT_VLD  = vld_q;
  assign bus.OUT_DAT_LST  = lst_q;
  assign bus.OUT_DAT_DAT  = dat_q;
  assign bus.OUT_DAT_INF  = inf_q;
  assign bus.OUT_DAT_IDX  = idx_q;
  assign bus.BUSY         = busy_q;

endmodule

// File: doc/cpm_topk_serializer.md
# cpm_topk_serializer

Drains the parallel top-K result produced by the CPM top-K sorter and replays it as a ranked serial stream with a valid/ready/last handshake. It sits directly downstream of the sorter in the CPM path. It snapshots the sorted arrays when the sorter flags completion and emits entries in rank order, largest first (index 0), feeding the result-writeback / classification stage.

## Interface
- DATA_DW, 8, width of each sorted data value
- INFO_DW, 8, width of each info tag
- SORT_DW, 32, number of entries in the top-K arrays
- SORT_AW, $clog2(SORT_DW), rank index width
- clk  input  1  clock; all logic on the rising edge
- rst_n  input  1  reset, asynchronous, active-low
- clear  input  1  synchronous clear; aborts any transfer
- CFG_NUM  input  SORT_AW+1  number of entries to emit; sampled at snapshot
- TOPK_DAT_VLD  input  1  sorter result valid (level; stays high until the sorter is cleared)
- TOPK_DAT_DAT  input  SORT_DW x DATA_DW  sorted data, index 0 = largest
- TOPK_DAT_INF  input  SORT_DW x INFO_DW  info tags aligned to data
- TOPK_DAT_RDY  output  1  high only in IDLE; snapshot taken when VLD && RDY
- OUT_DAT_VLD  output  1  serial beat valid
- OUT_DAT_RDY  input  1  downstream ready
- OUT_DAT_LST  output  1  marks final beat of the burst
- OUT_DAT_DAT  output  DATA_DW  entry data
- OUT_DAT_INF  output  INFO_DW  entry info
- OUT_DAT_IDX  output  SORT_AW  rank of the current entry
- BUSY  output  1  high in SEND or DONE

## Operation
- States: IDLE, SEND, DONE. Reset and clear both force IDLE.
- IDLE → SEND on TOPK_DAT_VLD. On that edge:
  - full DAT/INF arrays are copied into local buffers;
  - the effective count N is latched. N = CFG_NUM, clamped to SORT_DW when CFG_NUM is 0 or greater than SORT_DW;
  - the index counter is set to 0.
- SEND:
  - OUT_DAT_VLD = 1. OUT_DAT_DAT/INF = buffer[idx], OUT_DAT_IDX = idx. OUT_DAT_LST = (idx == N-1).
  - A beat completes when OUT_DAT_VLD && OUT_DAT_RDY. On a completed beat idx increments, or the block moves to DONE if LST.
- DONE:
  - OUT_DAT_VLD = 0.
  - Waits for TOPK_DAT_VLD == 0 (upstream cleared), then goes to IDLE. This prevents re-capturing the same level-held result.
- The snapshot decouples the block from upstream: changes to TOPK_DAT_* after capture have no effect on the current burst.
- The counter never exceeds N-1 and never wraps.

## Timing
- Reset values: TOPK_DAT_RDY=1, OUT_DAT_VLD=0, OUT_DAT_LST=0, OUT_DAT_DAT=0, OUT_DAT_INF=0, OUT_DAT_IDX=0, BUSY=0. Buffers are zero.
- Latency: TOPK_DAT_VLD seen high in IDLE at edge t → OUT_DAT_VLD high from t+1 with entry 0.
- Throughput: with OUT_DAT_RDY held high, one beat per cycle; N beats occupy cycles t+1 … t+N.
- Backpressure: while OUT_DAT_VLD && !OUT_DAT_RDY, the VLD/DAT/INF/IDX/LST outputs hold stable. VLD never drops before its beat completes.
- N=1: the first beat has LST=1.
- clear during SEND: at the next edge the outputs return to reset values and the state is IDLE, with no LST emitted. If TOPK_DAT_VLD is still high at that point, a new snapshot is taken on the following edge.
- clear and TOPK_DAT_VLD high in the same cycle: clear wins and no snapshot is taken.
- Asynchronous reset mid-burst: outputs go to reset values immediately.
- TOPK_DAT_RDY is combinational from state (IDLE).

## Test plan
- Load DAT = 31…0 (index 0 = 31), INF = index, CFG_NUM=4, RDY=1 → four beats on consecutive cycles: DAT 31,30,29,28; IDX 0..3; LST only on the 4th beat; then VLD=0.
- CFG_NUM=0 and CFG_NUM=40 → both emit 32 beats with LST on IDX=31.
- CFG_NUM=8, RDY toggling pseudo-randomly → every beat is held stable while stalled; exactly 8 handshakes; no duplicated or skipped IDX.
- TOPK_DAT_VLD held high after the burst → no second burst. Deassert VLD, then reassert with new data → a new burst carries the new data.
- Assert clear after the 3rd beat of a 10-entry burst → VLD=0 next cycle, outputs are zero, IDLE is reached. Reset pulse mid-burst → identical result.
- Change TOPK_DAT_DAT during SEND → emitted values still match the snapshot.
